// File: rtl/checkpoint_monitor.sv
// checkpoint_monitor: address checkpoint / run monitor for an instruction-fetch stream.
//
// A run is started by i_arm. While armed, each enabled channel compares fetch addresses
// against its programmed address and records sticky hits. A hit on a stop channel, a
// HLT strobe or a watchdog expiry ends the run. Status is frozen until the next arm.
//
// Optional feature: define CKPT_HIT_COUNT_EN to build per-channel 16-bit saturating
// hit counters readable through o_rd_count. Without it, o_rd_count is tied to zero.
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_fetch, i_address    fetch strobe and fetch address (bit 0 = MSB)
//   i_halt_det            HLT executed strobe
//   i_cfg_we, i_cfg_sel   channel config write strobe and channel index (also read select)
//   i_cfg_addr/en/stop    channel match address, enable, stop-on-hit
//   i_arm                 start / restart a monitored run
//   i_wd_limit            watchdog limit in cycles, 0 disables
//   o_hit                 sticky per-channel hit flags
//   o_last_ch             lowest index among the most recent hits
//   o_done                run terminated (stopped or timed out)
//   o_cause               00 none, 01 stop channel, 10 halt, 11 watchdog
//   o_stop_addr           fetch address captured at termination
//   o_rd_count            hit count of channel i_cfg_sel
module checkpoint_monitor #(
  parameter int unsigned NCH = 4,
  parameter int unsigned AW  = 15,
  parameter int unsigned TW  = 24
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_fetch,
  input  logic [0:AW-1] i_address,
  input  logic          i_halt_det,
  input  logic          i_cfg_we,
  input  logic [2:0]    i_cfg_sel,
  input  logic [0:AW-1] i_cfg_addr,
  input  logic          i_cfg_en,
  input  logic          i_cfg_stop,
  input  logic          i_arm,
  input  logic [0:TW-1] i_wd_limit,
  output logic [0:NCH-1] o_hit,
  output logic [2:0]    o_last_ch,
  output logic          o_done,
  output logic [1:0]    o_cause,
  output logic [0:AW-1] o_stop_addr,
  output logic [15:0]   o_rd_count
);

  typedef enum logic [1:0] {StIdle, StArmed, StStopped, StTimeout} state_t;

  state_t         r_state;
  logic [0:NCH-1] r_hit;
  logic [2:0]     r_last_ch;
  logic           r_done;
  logic [1:0]     r_cause;
  logic [0:AW-1]  r_stop_addr;
  logic [0:AW-1]  r_last_fetch;
  logic [TW-1:0]  r_wd;
  logic [0:AW-1]  r_ch_addr [NCH];
  logic [0:NCH-1] r_ch_en;
  logic [0:NCH-1] r_ch_stop;

  logic [0:NCH-1] w_match;
  logic [2:0]     w_first;
  logic           w_any_stop;
  logic [TW:0]    w_wd_inc;
  logic           w_wd_expire;

  always_comb begin
    for (int n = 0; n < NCH; n++) begin
      w_match[n] = i_fetch && r_ch_en[n] && (i_address == r_ch_addr[n]);
    end
  end

  // Lowest matching index wins when several channels hit together.
  always_comb begin
    w_first = '0;
    for (int n = NCH - 1; n >= 0; n--) begin
      if (w_match[n]) w_first = 3'(n);
    end
  end

  assign w_any_stop  = |(w_match & r_ch_stop);
  assign w_wd_inc    = {1'b0, r_wd} + {{TW{1'b0}}, 1'b1};
  assign w_wd_expire = (i_wd_limit != '0) && (w_wd_inc >= {1'b0, i_wd_limit});

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_hit        <= '0;
      r_last_ch    <= '0;
      r_done       <= 1'b0;
      r_cause      <= 2'b00;
      r_stop_addr  <= '0;
      r_last_fetch <= '0;
      r_wd         <= '0;
      r_ch_en      <= '0;
      r_ch_stop    <= '0;
      for (int n = 0; n < NCH; n++) r_ch_addr[n] <= '0;
    end else begin
      // Config writes land next cycle; indices >= NCH match no channel.
      for (int n = 0; n < NCH; n++) begin
        if (i_cfg_we && (i_cfg_sel == 3'(n))) begin
          r_ch_addr[n] <= i_cfg_addr;
          r_ch_en[n]   <= i_cfg_en;
          r_ch_stop[n] <= i_cfg_stop;
        end
      end

      if (i_arm) begin
        // Arm from any state (re-arm / restart) clears all run status.
        r_state      <= StArmed;
        r_hit        <= '0;
        r_last_ch    <= '0;
        r_done       <= 1'b0;
        r_cause      <= 2'b00;
        r_stop_addr  <= '0;
        r_last_fetch <= '0;
        r_wd         <= '0;
      end else if (r_state == StArmed) begin
        r_hit <= r_hit | w_match;
        if (|w_match) r_last_ch <= w_first;
        if (i_fetch) r_last_fetch <= i_address;

        if (w_any_stop) begin
          r_state     <= StStopped;
          r_done      <= 1'b1;
          r_cause     <= 2'b01;
          r_stop_addr <= i_address;
        end else if (i_halt_det) begin
          r_state     <= StStopped;
          r_done      <= 1'b1;
          r_cause     <= 2'b10;
          r_stop_addr <= i_fetch ? i_address : r_last_fetch;
        end else if (i_fetch) begin
          // A fetch always beats a coincident watchdog expiry.
          r_wd <= '0;
        end else if (w_wd_expire) begin
          r_state     <= StTimeout;
          r_done      <= 1'b1;
          r_cause     <= 2'b11;
          r_stop_addr <= r_last_fetch;
        end else begin
          r_wd <= w_wd_inc[TW-1:0];
        end
      end
    end
  end

`ifdef CKPT_HIT_COUNT_EN
  logic [15:0] r_cnt [NCH];

  always_ff @(posedge i_clk) begin
    if (i_reset || i_arm) begin
      for (int n = 0; n < NCH; n++) r_cnt[n] <= '0;
    end else if (r_state == StArmed) begin
      for (int n = 0; n < NCH; n++) begin
        if (w_match[n] && (r_cnt[n] != 16'hFFFF)) r_cnt[n] <= r_cnt[n] + 16'd1;
      end
    end
  end

  always_comb begin
    o_rd_count = '0;
    for (int n = 0; n < NCH; n++) begin
      if (i_cfg_sel == 3'(n)) o_rd_count = r_cnt[n];
    end
  end
`else
  assign o_rd_count = '0;
`endif

  assign o_hit       = r_hit;
  assign o_last_ch   = r_last_ch;
  assign o_done      = r_done;
  assign o_cause     = r_cause;
  assign o_stop_addr = r_stop_addr;

endmodule

// File: tb/tb_checkpoint_monitor.sv
module tb_checkpoint_monitor;
  localparam int NCH = 4;
  localparam int AW  = 15;
  localparam int TW  = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, fetch, halt_det, cfg_we, cfg_en, cfg_stop, arm;
  logic [2:0] cfg_sel;
  logic [AW-1:0] address, cfg_addr;
  logic [TW-1:0] wd_limit;
  logic [0:NCH-1] hit;
  logic [2:0] last_ch;
  logic done;
  logic [1:0] cause;
  logic [AW-1:0] stop_addr;
  logic [15:0] rd_count;

  checkpoint_monitor #(.NCH(NCH), .AW(AW), .TW(TW)) dut (
    .i_clk(clk), .i_reset(reset), .i_fetch(fetch), .i_address(address),
    .i_halt_det(halt_det), .i_cfg_we(cfg_we), .i_cfg_sel(cfg_sel),
    .i_cfg_addr(cfg_addr), .i_cfg_en(cfg_en), .i_cfg_stop(cfg_stop),
    .i_arm(arm), .i_wd_limit(wd_limit), .o_hit(hit), .o_last_ch(last_ch),
    .o_done(done), .o_cause(cause), .o_stop_addr(stop_addr), .o_rd_count(rd_count)
  );

  // Reference model: run phase 0 idle, 1 armed, 2 stopped, 3 timed out.
  int            m_phase;
  bit            m_hit [NCH];
  int            m_last_ch, m_cause;
  logic [AW-1:0] m_stop_addr, m_last_fetch;
  longint        m_idle_cycles;
  logic [AW-1:0] m_caddr [NCH];
  bit            m_cen [NCH], m_cstop [NCH];
  int            m_cnt [NCH];

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_run();
    for (int n = 0; n < NCH; n++) begin
      m_hit[n] = 0;
      m_cnt[n] = 0;
    end
    m_last_ch = 0; m_cause = 0; m_stop_addr = '0; m_last_fetch = '0; m_idle_cycles = 0;
  endtask

  task automatic model_step();
    bit any_stop;
    int first;
    if (reset) begin
      clear_run();
      m_phase = 0;
      for (int n = 0; n < NCH; n++) begin
        m_caddr[n] = '0; m_cen[n] = 0; m_cstop[n] = 0;
      end
      return;
    end
    if (arm) begin
      clear_run();
      m_phase = 1;
    end else if (m_phase == 1) begin
      any_stop = 0;
      first = -1;
      for (int n = 0; n < NCH; n++) begin
        if (fetch && m_cen[n] && address == m_caddr[n]) begin
          m_hit[n] = 1;
          if (first < 0) first = n;
          if (m_cstop[n]) any_stop = 1;
          if (m_cnt[n] < 65535) m_cnt[n]++;
        end
      end
      if (first >= 0) m_last_ch = first;
      if (any_stop) begin
        m_phase = 2; m_cause = 1; m_stop_addr = address;
      end else if (halt_det) begin
        m_phase = 2; m_cause = 2; m_stop_addr = fetch ? address : m_last_fetch;
      end else if (fetch) begin
        m_idle_cycles = 0;
      end else begin
        m_idle_cycles++;
        if (wd_limit != 0 && m_idle_cycles >= longint'(wd_limit)) begin
          m_phase = 3; m_cause = 3; m_stop_addr = m_last_fetch;
        end
      end
      if (fetch) m_last_fetch = address;
    end
    if (cfg_we && cfg_sel < NCH) begin
      m_caddr[cfg_sel] = cfg_addr; m_cen[cfg_sel] = cfg_en; m_cstop[cfg_sel] = cfg_stop;
    end
  endtask

  task automatic compare();
    logic [0:NCH-1] eh;
    logic [15:0] ec;
    for (int n = 0; n < NCH; n++) eh[n] = m_hit[n];
    ec = 16'h0;
`ifdef CKPT_HIT_COUNT_EN
    if (cfg_sel < NCH) ec = 16'(m_cnt[cfg_sel]);
`endif
    check("hit", 64'(hit), 64'(eh));
    check("last_ch", 64'(last_ch), 64'(m_last_ch));
    check("done", 64'(done), 64'(m_phase >= 2));
    check("cause", 64'(cause), 64'(m_cause));
    check("stop_addr", 64'(stop_addr), 64'(m_stop_addr));
    check("rd_count", 64'(rd_count), 64'(ec));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic quiet();
    reset = 0; fetch = 0; halt_det = 0; cfg_we = 0; arm = 0;
  endtask

  task automatic do_reset();
    quiet(); reset = 1; step(); reset = 0;
  endtask

  task automatic cfg(input int sel, input logic [AW-1:0] a, input bit en, input bit stp);
    quiet(); cfg_we = 1; cfg_sel = 3'(sel); cfg_addr = a; cfg_en = en; cfg_stop = stp;
    step(); cfg_we = 0;
  endtask

  task automatic do_arm();
    quiet(); arm = 1; step(); arm = 0;
  endtask

  task automatic do_fetch(input logic [AW-1:0] a, input bit h);
    quiet(); fetch = 1; address = a; halt_det = h; step(); quiet();
  endtask

  logic [AW-1:0] pool [4];
  int fetch_div;

  initial begin
    quiet();
    reset = 1; address = '0; cfg_sel = '0; cfg_addr = '0; cfg_en = 0; cfg_stop = 0;
    wd_limit = '0;
    m_phase = 0;
    clear_run();
    for (int n = 0; n < NCH; n++) begin
      m_caddr[n] = '0; m_cen[n] = 0; m_cstop[n] = 0;
    end
    do_reset();
    do_reset();
    check("reset_done", 64'(done), 64'(0));
    check("reset_hit", 64'(hit), 64'(0));

    // Stop channel terminates on its address.
    cfg(0, 15'o05276, 1, 1);
    do_arm();
    do_fetch(15'o00200, 0);
    check("pre_stop_done", 64'(done), 64'(0));
    do_fetch(15'o05276, 0);
    check("stop_hit", 64'(hit), 64'(4'b1000));
    check("stop_done", 64'(done), 64'(1));
    check("stop_cause", 64'(cause), 64'(2'b01));
    check("stop_addr_lit", 64'(stop_addr), 64'(15'o05276));
    do_fetch(15'o01234, 0);
    check("frozen_addr", 64'(stop_addr), 64'(15'o05276));

    // Two channels on one address, only the higher one stops.
    do_reset();
    cfg(1, 15'o00147, 1, 0);
    cfg(2, 15'o00147, 1, 1);
    do_arm();
    do_fetch(15'o00147, 0);
    check("multi_hit", 64'(hit), 64'(4'b0110));
    check("multi_last", 64'(last_ch), 64'(1));
    check("multi_cause", 64'(cause), 64'(2'b01));

    // Stop channel beats halt; halt alone gives cause 10 with last fetch address.
    do_reset();
    cfg(0, 15'o00300, 1, 1);
    do_arm();
    do_fetch(15'o00300, 1);
    check("prio_cause", 64'(cause), 64'(2'b01));
    do_arm();
    do_fetch(15'o00301, 0);
    quiet(); halt_det = 1; step(); quiet();
    check("halt_cause", 64'(cause), 64'(2'b10));
    check("halt_addr", 64'(stop_addr), 64'(15'o00301));

    // Watchdog.
    do_reset();
    wd_limit = 24'd10;
    do_arm();
    for (int i = 0; i < 9; i++) step();
    check("wd_9", 64'(done), 64'(0));
    step();
    check("wd_10_done", 64'(done), 64'(1));
    check("wd_cause", 64'(cause), 64'(2'b11));
    do_arm();
    for (int i = 0; i < 60; i++) begin
      quiet();
      if (i % 9 == 8) begin
        fetch = 1; address = 15'o07777;
      end
      step();
      check("wd_fed", 64'(done), 64'(0));
    end
    wd_limit = '0;

    // Reset mid-run after a hit.
    do_reset();
    cfg(3, 15'o00444, 1, 0);
    do_arm();
    do_fetch(15'o00444, 0);
    check("pre_rst_hit", 64'(hit), 64'(4'b0001));
    check("pre_rst_last", 64'(last_ch), 64'(3));
    do_reset();
    check("rst_hit", 64'(hit), 64'(0));
    check("rst_last", 64'(last_ch), 64'(0));
    do_fetch(15'o00444, 0);
    do_arm();
    do_fetch(15'o00444, 0);
    check("rst_cfg_cleared", 64'(hit), 64'(0));

    // Hit counter saturation (or tie-off when not built).
    do_reset();
    cfg(3, 15'o00555, 1, 0);
    do_arm();
    quiet(); fetch = 1; address = 15'o00555; cfg_sel = 3'd3;
`ifdef CKPT_HIT_COUNT_EN
    for (int i = 0; i < 70000; i++) step();
    check("cnt_sat", 64'(rd_count), 64'(16'hFFFF));
`else
    for (int i = 0; i < 20; i++) step();
    check("cnt_absent", 64'(rd_count), 64'(0));
`endif
    quiet();

    // Randomized traffic.
    pool[0] = 15'o05276; pool[1] = 15'o00147; pool[2] = 15'o00300; pool[3] = 15'o07001;
    do_reset();
    fetch_div = 3;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) begin
        wd_limit = TW'($urandom_range(0, 12));
        fetch_div = ($urandom_range(0, 1) == 0) ? 3 : 8;
      end
      reset    = ($urandom_range(0, 299) == 0);
      arm      = ($urandom_range(0, 29) == 0);
      fetch    = ($urandom_range(0, fetch_div - 1) == 0);
      address  = ($urandom_range(0, 2) != 0) ? pool[$urandom_range(0, 3)] : AW'($urandom);
      halt_det = ($urandom_range(0, 49) == 0);
      cfg_we   = ($urandom_range(0, 9) == 0);
      cfg_sel  = 3'($urandom_range(0, 7));
      cfg_addr = pool[$urandom_range(0, 3)];
      cfg_en   = ($urandom_range(0, 3) != 0);
      cfg_stop = ($urandom_range(0, 2) == 0);
      step();
    end
    quiet();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/checkpoint_monitor.md
CHECKPOINT_MONITOR -- requirements
Module: checkpoint_monitor

Interface
REQ-001 Parameter NCH, default 4: number of address checkpoint channels, 1..8.
REQ-002 Parameter AW, default 15: address width, bit 0 = MSB.
REQ-003 Parameter TW, default 24: watchdog counter width.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 fetch  input  1  one-cycle strobe marking a valid instruction-fetch address.
REQ-007 address  input  [0:AW-1]  fetch address, sampled only when fetch=1.
REQ-008 halt_det  input  1  one-cycle strobe: HLT instruction executed.
REQ-009 cfg_we  input  1  write strobe for channel configuration.
REQ-010 cfg_sel  input  3  channel index for cfg_we and rd_sel.
REQ-011 cfg_addr  input  [0:AW-1]  match address written to the selected channel.
REQ-012 cfg_en, cfg_stop  input  1 each  channel enable; channel hit terminates the run.
REQ-013 arm  input  1  one-cycle strobe starting a monitored run.
REQ-014 wd_limit  input  [0:TW-1]  watchdog limit in clk cycles; 0 disables the watchdog.
REQ-015 hit  output  [0:NCH-1]  sticky per-channel hit flags.
REQ-016 last_ch  output  3  index of the most recently hit channel.
REQ-017 done  output  1  high while in state STOPPED or TIMEOUT.
REQ-018 cause  output  2  00 none, 01 stop-channel hit, 10 halt, 11 watchdog.
REQ-019 stop_addr  output  [0:AW-1]  fetch address captured at termination.
REQ-020 rd_count  output  16  hit count of channel cfg_sel.

Function
REQ-021 States: IDLE, ARMED, STOPPED, TIMEOUT, encoded in 2 bits.
REQ-022 IDLE: arm=1 -> ARMED next cycle; clears hit, cause, last_ch, stop_addr, watchdog and hit counters.
REQ-023 ARMED: enabled channel n matches when fetch=1 and address==chan_addr[n]; hit[n] sets the following cycle.
REQ-024 Multiple simultaneous matches: all hit bits set; last_ch takes the lowest matching index.
REQ-025 ARMED: match on any channel with stop=1 -> STOPPED, cause=01, stop_addr=address, same edge as hit.
REQ-026 ARMED: halt_det=1 -> STOPPED, cause=10, stop_addr=last fetch address.
REQ-027 Stop-channel match and halt_det in the same cycle: cause=01 wins.
REQ-028 Watchdog counts clk cycles in ARMED, clears on every fetch; reaching wd_limit (nonzero) -> TIMEOUT, cause=11.
REQ-029 Watchdog expiry coincident with fetch: fetch wins, watchdog clears, no TIMEOUT.
REQ-030 STOPPED/TIMEOUT: outputs frozen; arm=1 -> ARMED with all status cleared (re-arm); fetches ignored.
REQ-031 arm while ARMED restarts the run: status cleared, state stays ARMED.
REQ-032 cfg_we takes effect the next cycle in any state; cfg_sel>=NCH ignored; mid-run rewrites apply to subsequent fetches only.
REQ-033 Latency from fetch/halt_det to hit/done/cause is exactly one clk.

Reset
REQ-034 reset=1 at any edge, including mid-run: state=IDLE, hit=0, last_ch=0, done=0, cause=00, stop_addr=0, rd_count=0, watchdog=0.
REQ-035 Reset clears all channel enables and stop bits; channel addresses reset to 0.

Configuration
REQ-036 Macro CKPT_HIT_COUNT_EN defined: per-channel 16-bit saturating hit counters (stop at 16'hFFFF), incremented on each match in ARMED, cleared on arm, read via rd_count by cfg_sel.
REQ-037 CKPT_HIT_COUNT_EN undefined: no counters synthesised; rd_count tied to 0; all other behaviour unchanged.

Verification
REQ-038 Ch0=15'o05276 stop=1, arm, fetch 15'o00200, 15'o05276 -> next cycle hit[0]=1, done=1, cause=01, stop_addr=15'o05276.
REQ-039 Ch1=15'o00147 stop=0, ch2=15'o00147 stop=1, one fetch of 15'o00147 -> hit=0110, last_ch=1, cause=01.
REQ-040 wd_limit=10, arm, no fetch for 10 cycles -> TIMEOUT, cause=11; repeat with fetch every 9 cycles -> never done.
REQ-041 Ch0=15'o00300 stop=1, fetch 15'o00300 with halt_det same cycle -> cause=01; halt_det alone -> cause=10.
REQ-042 With CKPT_HIT_COUNT_EN, ch3 stop=0, 70000 matching fetches -> rd_count(cfg_sel=3)=16'hFFFF; without macro rd_count=0.
REQ-043 reset asserted in ARMED after a hit -> next cycle all outputs zero, state IDLE; fetch of old match address sets nothing.
